// File: rtl/pixel_store_memory_if.sv
// Pixel store access bus: write port, read port, clear request and status.
interface pixel_store_memory_if #(
  parameter int unsigned CHANNELS      = 3,
  parameter int unsigned CHANNEL_WIDTH = 8,
  parameter int unsigned BUS_WIDTH     = 32
);
  logic                                Mem_Write_Enable;
  logic [CHANNELS-1:0]                 Mem_Write_Mask;
  logic [BUS_WIDTH-1:0]                Mem_Write_Address;
  logic [CHANNELS*CHANNEL_WIDTH-1:0]   Mem_Input_Data;
  logic                                Mem_Read_Enable;
  logic [BUS_WIDTH-1:0]                Mem_Read_Address;
  logic                                Mem_Clear;
  logic [CHANNELS*CHANNEL_WIDTH-1:0]   Mem_Output_Data;
  logic                                Mem_Read_Valid;
  logic                                Mem_Busy;
  logic                                Mem_Error;

  modport master (
    output Mem_Write_Enable, Mem_Write_Mask, Mem_Write_Address, Mem_Input_Data,
    output Mem_Read_Enable, Mem_Read_Address, Mem_Clear,
    input  Mem_Output_Data, Mem_Read_Valid, Mem_Busy, Mem_Error
  );

  modport slave (
    input  Mem_Write_Enable, Mem_Write_Mask, Mem_Write_Address, Mem_Input_Data,
    input  Mem_Read_Enable, Mem_Read_Address, Mem_Clear,
    output Mem_Output_Data, Mem_Read_Valid, Mem_Busy, Mem_Error
  );
endinterface

// File: rtl/pixel_store_memory.sv
// Byte-addressed pixel store: masked pixel writes, registered pixel reads,
// range checking with an error strobe, and a strided multi-cycle clear.
module pixel_store_memory #(
  parameter int unsigned CHANNELS      = 3,
  parameter int unsigned CHANNEL_WIDTH = 8,
  parameter int unsigned BUS_WIDTH     = 32,
  parameter int unsigned MEMORY_DEPTH  = 4194304,
  parameter int unsigned CLEAR_STRIDE  = 4,
  parameter int unsigned LITTLE_ENDIAN = 0
) (
  input  logic                 Mem_Clk,
  input  logic                 Mem_Reset_n,
  pixel_store_memory_if.slave  bus
);

  localparam int unsigned AW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam int unsigned PW = CHANNELS * CHANNEL_WIDTH;

  localparam logic [BUS_WIDTH:0] DEPTH_X  = (BUS_WIDTH+1)'(MEMORY_DEPTH);
  localparam logic [BUS_WIDTH:0] CHAN_X   = (BUS_WIDTH+1)'(CHANNELS);
  localparam logic [AW-1:0]      LAST_PTR = AW'(MEMORY_DEPTH - CLEAR_STRIDE);
  localparam logic [AW-1:0]      STRIDE   = AW'(CLEAR_STRIDE);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t              state, state_next;
  logic [AW-1:0]       clr_ptr, ptr_next;

  logic [CHANNEL_WIDTH-1:0] mem [MEMORY_DEPTH];

  logic [BUS_WIDTH:0]  wr_end, rd_end;
  logic                wr_in_range, rd_in_range;
  logic                idle_ok, wr_ok, rd_ok, err;
  logic [AW-1:0]       wr_base, rd_base;
  logic [PW-1:0]       rd_pixel;

  logic [PW-1:0]       out_q;
  logic                valid_q, error_q;

  // Data slice holding the byte stored at address offset j.
  function automatic int unsigned lane(input int unsigned j);
    return (LITTLE_ENDIAN != 0) ? j : (CHANNELS - 1 - j);
  endfunction

  // Range check carries one extra bit so a high address cannot wrap into range.
  always_comb begin
    wr_end      = {1'b0, bus.Mem_Write_Address} + CHAN_X;
    rd_end      = {1'b0, bus.Mem_Read_Address} + CHAN_X;
    wr_in_range = (wr_end <= DEPTH_X);
    rd_in_range = (rd_end <= DEPTH_X);
    wr_base     = bus.Mem_Write_Address[AW-1:0];
    rd_base     = bus.Mem_Read_Address[AW-1:0];
    idle_ok     = (state == S_IDLE) && !bus.Mem_Clear;
    wr_ok       = bus.Mem_Write_Enable && idle_ok && wr_in_range;
    rd_ok       = bus.Mem_Read_Enable && idle_ok && rd_in_range;
    err         = (bus.Mem_Write_Enable && !wr_ok) || (bus.Mem_Read_Enable && !rd_ok);
  end

  // Assemble the read pixel from the current (pre-write) array contents.
  always_comb begin
    rd_pixel = '0;
    for (int unsigned j = 0; j < CHANNELS; j++) begin
      rd_pixel[lane(j)*CHANNEL_WIDTH +: CHANNEL_WIDTH] = mem[rd_base + AW'(j)];
    end
  end

  // FSM next state and clear pointer advance.
  always_comb begin
    state_next = state;
    ptr_next   = clr_ptr;
    case (state)
      S_IDLE: begin
        if (bus.Mem_Clear) begin
          state_next = S_CLEAR;
          ptr_next   = '0;
        end
      end
      S_CLEAR: begin
        ptr_next = clr_ptr + STRIDE;
        if (clr_ptr == LAST_PTR) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM state and clear pointer registers.
  always_ff @(posedge Mem_Clk or negedge Mem_Reset_n) begin
    if (!Mem_Reset_n) begin
      state   <= S_IDLE;
      clr_ptr <= '0;
    end else begin
      state   <= state_next;
      clr_ptr <= ptr_next;
    end
  end

  // Array update: clear sweep stride, or masked pixel write; never reset.
  always_ff @(posedge Mem_Clk) begin
    if (state == S_CLEAR) begin
      for (int unsigned s = 0; s < CLEAR_STRIDE; s++) begin
        mem[clr_ptr + AW'(s)] <= '0;
      end
    end else if (wr_ok) begin
      for (int unsigned j = 0; j < CHANNELS; j++) begin
        if (bus.Mem_Write_Mask[j]) begin
          mem[wr_base + AW'(j)] <= bus.Mem_Input_Data[lane(j)*CHANNEL_WIDTH +: CHANNEL_WIDTH];
        end
      end
    end
  end

  // Registered read data, valid strobe and error strobe.
  always_ff @(posedge Mem_Clk or negedge Mem_Reset_n) begin
    if (!Mem_Reset_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      valid_q <= rd_ok;
      error_q <= err;
      if (rd_ok) begin
        out_q <= rd_pixel;
      end
    end
  end

  assign bus.Mem_Output_Data = out_q;
  assign bus.Mem_Read_Valid  = valid_q;
  assign bus.Mem_Error       = error_q;
  assign bus.Mem_Busy        = (state == S_CLEAR);

endmodule

// File: tb/tb_pixel_store_memory.sv
// Bench for pixel_store_memory: a big-endian and a little-endian instance,
// byte-array reference model and a queue of expected read pixels.
module tb_pixel_store_memory;

  localparam int unsigned DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pixel_store_memory_if #(.CHANNELS(3), .CHANNEL_WIDTH(8), .BUS_WIDTH(32)) bb ();
  pixel_store_memory_if #(.CHANNELS(3), .CHANNEL_WIDTH(8), .BUS_WIDTH(32)) bl ();

  pixel_store_memory #(
    .CHANNELS(3), .CHANNEL_WIDTH(8), .BUS_WIDTH(32),
    .MEMORY_DEPTH(DEPTH), .CLEAR_STRIDE(4), .LITTLE_ENDIAN(0)
  ) u_be (
    .Mem_Clk(clk), .Mem_Reset_n(rst_n), .bus(bb)
  );

  pixel_store_memory #(
    .CHANNELS(3), .CHANNEL_WIDTH(8), .BUS_WIDTH(32),
    .MEMORY_DEPTH(DEPTH), .CLEAR_STRIDE(4), .LITTLE_ENDIAN(1)
  ) u_le (
    .Mem_Clk(clk), .Mem_Reset_n(rst_n), .bus(bl)
  );

  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q [$];
  logic [23:0] le_q [$];
  logic [7:0]  mdl [DEPTH];
  bit          tb_busy = 1'b0;
  logic [23:0] exp;

  // Drive one cycle on the big-endian instance; queue expected read data and
  // update the reference model for writes the bench expects to be accepted.
  task automatic step(input bit we, input logic [2:0] mask, input logic [31:0] wa,
                      input logic [23:0] wd, input bit re, input logic [31:0] ra,
                      input bit clr);
    bit idle_ok;
    idle_ok = !tb_busy && !clr;
    bb.Mem_Write_Enable  = we;
    bb.Mem_Write_Mask    = mask;
    bb.Mem_Write_Address = wa;
    bb.Mem_Input_Data    = wd;
    bb.Mem_Read_Enable   = re;
    bb.Mem_Read_Address  = ra;
    bb.Mem_Clear         = clr;
    if (re && idle_ok && (64'(ra) + 64'd3 <= 64'(DEPTH)))
      exp_q.push_back({mdl[ra], mdl[ra+1], mdl[ra+2]});
    if (we && idle_ok && (64'(wa) + 64'd3 <= 64'(DEPTH))) begin
      for (int j = 0; j < 3; j++)
        if (mask[j]) mdl[wa+j] = wd[(2-j)*8 +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step_le(input bit we, input logic [2:0] mask, input logic [31:0] wa,
                         input logic [23:0] wd, input bit re, input logic [31:0] ra);
    bl.Mem_Write_Enable  = we;
    bl.Mem_Write_Mask    = mask;
    bl.Mem_Write_Address = wa;
    bl.Mem_Input_Data    = wd;
    bl.Mem_Read_Enable   = re;
    bl.Mem_Read_Address  = ra;
    bl.Mem_Clear         = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 3'b000, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(0, 3'b000, 0, 0, 0, 0, 0);
    step_le(0, 3'b000, 0, 0, 0, 0);
    checks++;
    if (bb.Mem_Output_Data !== 24'h0 || bb.Mem_Read_Valid !== 1'b0 ||
        bb.Mem_Busy !== 1'b0 || bb.Mem_Error !== 1'b0) begin
      errors++;
      $display("FAIL reset_be: out=%h valid=%b busy=%b err=%b, required all zero",
               bb.Mem_Output_Data, bb.Mem_Read_Valid, bb.Mem_Busy, bb.Mem_Error);
    end
    checks++;
    if (bl.Mem_Output_Data !== 24'h0 || bl.Mem_Read_Valid !== 1'b0 ||
        bl.Mem_Busy !== 1'b0 || bl.Mem_Error !== 1'b0) begin
      errors++;
      $display("FAIL reset_le: out=%h valid=%b busy=%b err=%b, required all zero",
               bl.Mem_Output_Data, bl.Mem_Read_Valid, bl.Mem_Busy, bl.Mem_Error);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_big_endian();
    step(1, 3'b111, 7, 24'h000000, 0, 0, 0);
    step(1, 3'b111, 10, 24'hA1B2C3, 0, 0, 0);
    step(0, 3'b000, 0, 0, 1, 10, 0);
    checks++;
    if (bb.Mem_Read_Valid !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL be_read10_valid: valid=%b queued=%0d, required 1", bb.Mem_Read_Valid, exp_q.size());
    end else begin
      exp = exp_q.pop_front();
      checks++;
      if (bb.Mem_Output_Data !== exp || exp !== 24'hA1B2C3) begin
        errors++;
        $display("FAIL be_read10: got %h, required %h", bb.Mem_Output_Data, exp);
      end
    end
    idle();
    checks++;
    if (bb.Mem_Read_Valid !== 1'b0 || bb.Mem_Output_Data !== 24'hA1B2C3) begin
      errors++;
      $display("FAIL be_valid_pulse: valid=%b out=%h, required 0 and held A1B2C3",
               bb.Mem_Read_Valid, bb.Mem_Output_Data);
    end
    step(0, 3'b000, 0, 0, 1, 8, 0);
    checks++;
    if (bb.Mem_Read_Valid !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL be_read8_valid: valid=%b, required 1", bb.Mem_Read_Valid);
    end else begin
      exp = exp_q.pop_front();
      checks++;
      if (bb.Mem_Output_Data !== exp || exp !== 24'h0000A1) begin
        errors++;
        $display("FAIL be_read8: got %h, required %h", bb.Mem_Output_Data, exp);
      end
    end
  endtask

  task automatic test_mask_little_endian();
    step_le(1, 3'b111, 3, 24'h000000, 0, 0);
    step_le(1, 3'b111, 0, 24'h112233, 0, 0);
    step_le(1, 3'b010, 0, 24'hFFFFFF, 0, 0);
    le_q.push_back(24'h11FF33);
    step_le(0, 3'b000, 0, 0, 1, 0);
    checks++;
    if (bl.Mem_Read_Valid !== 1'b1) begin
      errors++;
      $display("FAIL le_read0_valid: valid=%b, required 1", bl.Mem_Read_Valid);
    end else begin
      exp = le_q.pop_front();
      checks++;
      if (bl.Mem_Output_Data !== exp) begin
        errors++;
        $display("FAIL le_read0: got %h, required %h", bl.Mem_Output_Data, exp);
      end
    end
    // Locations 1..3 hold FF, 11, 00; LSBs come from the lowest address.
    le_q.push_back(24'h0011FF);
    step_le(0, 3'b000, 0, 0, 1, 1);
    checks++;
    if (bl.Mem_Read_Valid !== 1'b1) begin
      errors++;
      $display("FAIL le_read1_valid: valid=%b, required 1", bl.Mem_Read_Valid);
    end else begin
      exp = le_q.pop_front();
      checks++;
      if (bl.Mem_Output_Data !== exp) begin
        errors++;
        $display("FAIL le_read1: got %h, required %h", bl.Mem_Output_Data, exp);
      end
    end
    step_le(0, 3'b000, 0, 0, 0, 0);
  endtask

  task automatic test_range();
    step(1, 3'b111, 61, 24'h123456, 0, 0, 0);
    checks++;
    if (bb.Mem_Error !== 1'b0) begin
      errors++;
      $display("FAIL range_wr61_err: err=%b, required 0", bb.Mem_Error);
    end
    step(0, 3'b000, 0, 0, 1, 61, 0);
    checks++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hxxxxxx;
    if (bb.Mem_Read_Valid !== 1'b1 || bb.Mem_Output_Data !== exp) begin
      errors++;
      $display("FAIL range_rd61: valid=%b got %h, required 1 %h", bb.Mem_Read_Valid, bb.Mem_Output_Data, exp);
    end
    // Both ports rejected in one cycle: single error pulse, output held.
    step(1, 3'b111, 62, 24'hDEADBE, 1, 32'hFFFF_FFFF, 0);
    checks++;
    if (bb.Mem_Error !== 1'b1 || bb.Mem_Read_Valid !== 1'b0 || bb.Mem_Output_Data !== 24'h123456) begin
      errors++;
      $display("FAIL range_reject: err=%b valid=%b out=%h, required 1 0 123456",
               bb.Mem_Error, bb.Mem_Read_Valid, bb.Mem_Output_Data);
    end
    idle();
    checks++;
    if (bb.Mem_Error !== 1'b0) begin
      errors++;
      $display("FAIL range_err_pulse: err=%b, required 0", bb.Mem_Error);
    end
    step(0, 3'b000, 0, 0, 1, 61, 0);
    checks++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hxxxxxx;
    if (bb.Mem_Read_Valid !== 1'b1 || bb.Mem_Output_Data !== exp || exp !== 24'h123456) begin
      errors++;
      $display("FAIL range_unchanged: got %h, required %h", bb.Mem_Output_Data, exp);
    end
  endtask

  task automatic test_same_edge();
    step(1, 3'b111, 20, 24'h010203, 0, 0, 0);
    step(1, 3'b111, 20, 24'h0A0B0C, 1, 20, 0);
    checks++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hxxxxxx;
    if (bb.Mem_Read_Valid !== 1'b1 || bb.Mem_Output_Data !== exp || exp !== 24'h010203) begin
      errors++;
      $display("FAIL same_edge_read_first: got %h, required %h", bb.Mem_Output_Data, exp);
    end
    step(0, 3'b000, 0, 0, 1, 20, 0);
    checks++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hxxxxxx;
    if (bb.Mem_Read_Valid !== 1'b1 || bb.Mem_Output_Data !== exp || exp !== 24'h0A0B0C) begin
      errors++;
      $display("FAIL same_edge_after: got %h, required %h", bb.Mem_Output_Data, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    addrs = '{10, 20, 61, 7};
    foreach (addrs[i]) begin
      step(0, 3'b000, 0, 0, 1, addrs[i], 0);
      checks++;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hxxxxxx;
      if (bb.Mem_Read_Valid !== 1'b1 || bb.Mem_Output_Data !== exp) begin
        errors++;
        $display("FAIL b2b_read[%0d]: valid=%b got %h, required 1 %h",
                 i, bb.Mem_Read_Valid, bb.Mem_Output_Data, exp);
      end
    end
    idle();
  endtask

  task automatic fill_5a();
    for (int a = 0; a <= 60; a += 3) step(1, 3'b111, a, 24'h5A5A5A, 0, 0, 0);
    step(1, 3'b111, 61, 24'h5A5A5A, 0, 0, 0);
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a <= 61; a += (a == 60) ? 1 : 3) begin
      step(0, 3'b000, 0, 0, 1, a, 0);
      checks++;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hxxxxxx;
      if (bb.Mem_Read_Valid !== 1'b1 || bb.Mem_Output_Data !== exp) begin
        errors++;
        $display("FAIL %s addr %0d: valid=%b got %h, required 1 %h",
                 tag, a, bb.Mem_Read_Valid, bb.Mem_Output_Data, exp);
      end
    end
  endtask

  task automatic test_clear();
    int busy_cycles;
    int guard;
    fill_5a();
    busy_cycles = 0;
    step(0, 3'b000, 0, 0, 0, 0, 1);
    tb_busy = 1'b1;
    if (bb.Mem_Busy === 1'b1) busy_cycles++;
    step(1, 3'b111, 0, 24'h123456, 0, 0, 0);
    checks++;
    if (bb.Mem_Error !== 1'b1) begin
      errors++;
      $display("FAIL clear_busy_write_err: err=%b, required 1", bb.Mem_Error);
    end
    if (bb.Mem_Busy === 1'b1) busy_cycles++;
    guard = 0;
    while (bb.Mem_Busy === 1'b1 && guard < 100) begin
      idle();
      guard++;
      if (bb.Mem_Busy === 1'b1) busy_cycles++;
    end
    checks++;
    if (busy_cycles != 16 || guard >= 100) begin
      errors++;
      $display("FAIL clear_busy_len: busy cycles %0d, required 16", busy_cycles);
    end
    tb_busy = 1'b0;
    for (int a = 0; a < DEPTH; a++) mdl[a] = 8'h00;
    read_all("clear_zero");
  endtask

  task automatic test_reset_mid_clear();
    fill_5a();
    step(0, 3'b000, 0, 0, 1, 20, 0);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hxxxxxx;
    checks++;
    if (bb.Mem_Output_Data !== exp || exp !== 24'h5A5A5A) begin
      errors++;
      $display("FAIL midclr_preload: got %h, required %h", bb.Mem_Output_Data, exp);
    end
    step(0, 3'b000, 0, 0, 0, 0, 1);
    tb_busy = 1'b1;
    repeat (5) idle();
    rst_n = 1'b0;
    #2;
    checks++;
    if (bb.Mem_Output_Data !== 24'h0 || bb.Mem_Read_Valid !== 1'b0 ||
        bb.Mem_Busy !== 1'b0 || bb.Mem_Error !== 1'b0) begin
      errors++;
      $display("FAIL midclr_reset_outputs: out=%h valid=%b busy=%b err=%b, required all zero",
               bb.Mem_Output_Data, bb.Mem_Read_Valid, bb.Mem_Busy, bb.Mem_Error);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bb.Mem_Busy !== 1'b0) begin
      errors++;
      $display("FAIL midclr_idle: busy=%b, required 0", bb.Mem_Busy);
    end
    tb_busy = 1'b0;
    for (int a = 0; a < 20; a++) mdl[a] = 8'h00;
    read_all("midclr_contents");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_big_endian();
    test_mask_little_endian();
    test_range();
    test_same_edge();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
